hammer_sprite_ctrl: RTL and testbench
=====================================

Name: hammer_sprite_ctrl

Overview:
- Sequences the hammer sprite stored in the hammer bitmap RAM, a 2**ADDR_WIDTH x DATA_WIDTH RAM with one read port, one write port and 1-cycle registered read.
- Generates read addresses from the VGA pixel coordinate and the sprite origin.
- Runs the swing animation FSM that selects one of four 16x16 frames.
- Arbitrates host bitmap writes onto the RAM write port; writes are blocked while an animation is in progress.
- Sits between the VGA sync/game logic and the RAM; drives the pixel mux.

Parameters:
- ADDR_WIDTH, 10: RAM address width; must equal log2(FRAMES*SPR_W*SPR_H).
- DATA_WIDTH, 4: colour depth.
- SPR_W, 16: sprite width in pixels (power of 2).
- SPR_H, 16: sprite height in pixels (power of 2).
- HOLD_TICKS, 6: number of frame_tick pulses the strike frame is held.
- TRANSP, 0: colour code treated as transparent.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- x  in  10  current pixel column
- y  in  10  current pixel row
- org_x  in  10  sprite top-left column
- org_y  in  10  sprite top-left row
- frame_tick  in  1  one-cycle pulse per video frame
- swing  in  1  one-cycle request to start a swing
- busy  out  1  high while the FSM is not IDLE
- hit  out  1  one-cycle pulse on entry to STRIKE
- addr_r  out  ADDR_WIDTH  RAM read address
- ram_dout  in  DATA_WIDTH  RAM read data
- hammer_on  out  1  sprite pixel visible
- hammer_rgb  out  DATA_WIDTH  sprite colour
- wr_req  in  1  host write request (level)
- wr_addr  in  ADDR_WIDTH  host write address
- wr_data  in  DATA_WIDTH  host write data
- wr_ack  out  1  one-cycle grant pulse
- we  out  1  RAM write enable
- addr_w  out  ADDR_WIDTH  RAM write address
- din  out  DATA_WIDTH  RAM write data

Behaviour:
Reset (asynchronous, reset_n=0): FSM=IDLE, frame=0, hold counter=0. All outputs 0: busy, hit, addr_r, hammer_on, hammer_rgb, wr_ack, we, addr_w, din. Pipeline valid bits are cleared. Reset mid-swing aborts to IDLE with no hit pulse.

Animation FSM (updates only on frame_tick, except IDLE->WIND):
- IDLE (frame 0): swing=1 -> WIND on the next clk. A swing pulse in any other state is ignored, not queued.
- WIND (frame 1): frame_tick -> STRIKE; hit=1 for the one cycle of entry; hold counter cleared.
- STRIKE (frame 2): each frame_tick increments the hold counter; the frame_tick at which the counter equals HOLD_TICKS-1 -> RECOVER.
- RECOVER (frame 3): frame_tick -> IDLE.
- busy = (state != IDLE), registered.

Read pipeline (3-cycle latency from x/y to hammer_on/hammer_rgb):
- Stage 0 (combinational): dx = x - org_x and dy = y - org_y, both 10-bit unsigned wrap. in_box = (dx < SPR_W) && (dy < SPR_H). Negative offsets wrap large and are therefore excluded.
- Cycle N+1: addr_r <= {frame, dy[log2 SPR_H-1:0], dx[log2 SPR_W-1:0]}. in_box_d1 <= in_box. frame is sampled here, so a frame change never tears a pixel.
- Cycle N+2: RAM presents ram_dout. in_box_d2 <= in_box_d1.
- Cycle N+3: hammer_on <= in_box_d2 && (ram_dout != TRANSP). hammer_rgb <= ram_dout when in_box_d2, else 0.
- Outside the box, addr_r holds its last value.

Write arbiter:
- Grant condition: wr_req=1 && state==IDLE && swing==0 in that cycle. swing has priority; a simultaneous swing defers the write.
- On grant, next cycle: we=1, addr_w=wr_addr, din=wr_data, wr_ack=1, each for exactly 1 cycle.
- After an ack, the host must drop wr_req or present the next word. A held wr_req yields back-to-back grants every other cycle: grant, ack/idle, grant.
- While busy=1, wr_req stalls with no ack. The granted write completes even if a swing arrives in the ack cycle.
- we is never asserted while busy=1, except for the completing write above.

Test Plan:
- Reset: drive reset_n=0 mid-STRIKE -> busy=0, hit=0, we=0, addr_r=0 immediately; after release, FSM is IDLE with frame 0.
- Addressing: org=(100,50), x=103, y=52, frame 0 -> addr_r=0x023 one cycle later. Preload RAM[0x023]=5 -> hammer_on=1, hammer_rgb=5 three cycles after x/y. x=99 -> hammer_on=0 (wrap excluded).
- Transparency: RAM word=TRANSP(0) inside the box -> hammer_on=0, hammer_rgb=0.
- Swing sequence: swing pulse, then frame_ticks -> frames 1, 2 (hit pulses once), 2 held for exactly 6 ticks, then 3, then 0. busy high throughout. A second swing during STRIKE is ignored.
- Write arbitration: wr_req with addr=0x1FF, data=0xA in IDLE -> next cycle we=1, addr_w=0x1FF, din=0xA, wr_ack=1. wr_req during WIND -> no ack until IDLE, then ack.
- Simultaneous: swing and wr_req in the same IDLE cycle -> FSM enters WIND; no write until the return to IDLE.

Source files
------------

// File: rtl/hammer_sprite_ctrl_if.sv
// Hammer sprite bus: RAM read/write ports plus host bitmap-write handshake.
//   master : sprite controller (drives RAM address/write, grants host writes)
//   slave  : RAM + host side (returns read data, issues write requests)
interface hammer_sprite_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 4
);
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [DATA_WIDTH-1:0] ram_dout;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr_w;
  logic [DATA_WIDTH-1:0] din;
  logic                  wr_req;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_ack;

  modport master (
    output addr_r, we, addr_w, din, wr_ack,
    input  ram_dout, wr_req, wr_addr, wr_data
  );

  modport slave (
    input  addr_r, we, addr_w, din, wr_ack,
    output ram_dout, wr_req, wr_addr, wr_data
  );
endinterface

// File: rtl/hammer_sprite_ctrl.sv
// Hammer sprite controller: swing animation FSM, 3-stage pixel read pipeline
// into the sprite bitmap RAM, and host write arbitration onto the RAM write port.
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   x, y                    current VGA pixel coordinate
//   org_x, org_y            sprite top-left corner
//   frame_tick, swing       per-frame pulse, swing request pulse
//   busy, hit               animation active, one-cycle strike-entry pulse
//   hammer_on, hammer_rgb   pixel visibility and colour to the pixel mux
//   bus (master)            RAM read/write ports and host write handshake
module hammer_sprite_ctrl #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned SPR_W      = 16,
  parameter int unsigned SPR_H      = 16,
  parameter int unsigned HOLD_TICKS = 6,
  parameter int unsigned TRANSP     = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [9:0]            x,
  input  logic [9:0]            y,
  input  logic [9:0]            org_x,
  input  logic [9:0]            org_y,
  input  logic                  frame_tick,
  input  logic                  swing,
  output logic                  busy,
  output logic                  hit,
  output logic                  hammer_on,
  output logic [DATA_WIDTH-1:0] hammer_rgb,
  hammer_sprite_ctrl_if.master  bus
);

  localparam int unsigned XB      = $clog2(SPR_W);
  localparam int unsigned YB      = $clog2(SPR_H);
  localparam int unsigned FRAME_W = ADDR_WIDTH - XB - YB;
  localparam int unsigned HOLD_W  = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

  localparam logic [9:0]            SPR_W_L   = 10'(SPR_W);
  localparam logic [9:0]            SPR_H_L   = 10'(SPR_H);
  localparam logic [HOLD_W-1:0]     HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);
  localparam logic [DATA_WIDTH-1:0] TRANSP_L  = DATA_WIDTH'(TRANSP);

  // Encoding doubles as the displayed frame number.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WIND    = 2'd1,
    STRIKE  = 2'd2,
    RECOVER = 2'd3
  } state_t;

  state_t            state, state_next;
  logic [HOLD_W-1:0] hold, hold_next;
  logic              hit_next;
  logic              busy_next;

  logic [9:0] dx_c;
  logic [9:0] dy_c;
  logic       in_box_c;
  logic       in_box_d1;
  logic       in_box_d2;
  logic       grant_c;

  // Animation state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      hold  <= '0;
      busy  <= 1'b0;
      hit   <= 1'b0;
    end else begin
      state <= state_next;
      hold  <= hold_next;
      busy  <= busy_next;
      hit   <= hit_next;
    end
  end

  // Next-state: only IDLE->WIND reacts to swing; all other moves wait for frame_tick.
  always_comb begin
    state_next = state;
    hold_next  = hold;
    hit_next   = 1'b0;
    unique case (state)
      IDLE: begin
        if (swing) state_next = WIND;
      end
      WIND: begin
        if (frame_tick) begin
          state_next = STRIKE;
          hit_next   = 1'b1;
          hold_next  = '0;
        end
      end
      STRIKE: begin
        if (frame_tick) begin
          if (hold == HOLD_LAST) state_next = RECOVER;
          else                   hold_next  = hold + HOLD_W'(1);
        end
      end
      RECOVER: begin
        if (frame_tick) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    busy_next = (state_next != IDLE);
  end

  // Sprite-relative offset; negative offsets wrap large and fall outside the box.
  assign dx_c     = x - org_x;
  assign dy_c     = y - org_y;
  assign in_box_c = (dx_c < SPR_W_L) && (dy_c < SPR_H_L);

  // Read pipeline: address (frame sampled here), RAM latency, then colour/visibility.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.addr_r <= '0;
      in_box_d1  <= 1'b0;
      in_box_d2  <= 1'b0;
      hammer_on  <= 1'b0;
      hammer_rgb <= '0;
    end else begin
      if (in_box_c) begin
        bus.addr_r <= {FRAME_W'(state), dy_c[YB-1:0], dx_c[XB-1:0]};
      end
      in_box_d1  <= in_box_c;
      in_box_d2  <= in_box_d1;
      hammer_on  <= in_box_d2 && (bus.ram_dout != TRANSP_L);
      hammer_rgb <= in_box_d2 ? bus.ram_dout : '0;
    end
  end

  // Grant only in IDLE without a competing swing; the ack cycle itself never
  // grants, so a held request alternates grant / idle.
  assign grant_c = bus.wr_req && (state == IDLE) && !swing && !bus.wr_ack;

  // Write port: one-cycle write strobe and ack per grant.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.we     <= 1'b0;
      bus.wr_ack <= 1'b0;
      bus.addr_w <= '0;
      bus.din    <= '0;
    end else begin
      bus.we     <= grant_c;
      bus.wr_ack <= grant_c;
      bus.addr_w <= grant_c ? bus.wr_addr : '0;
      bus.din    <= grant_c ? bus.wr_data : '0;
    end
  end

endmodule

// File: tb/tb_hammer_sprite_ctrl.sv
// Self-checking bench for hammer_sprite_ctrl with a behavioural RAM and a
// reference model of pixel addressing and the swing frame timeline.
module tb_hammer_sprite_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [9:0] x, y, org_x, org_y;
  logic       frame_tick, swing;
  logic       busy, hit, hammer_on;
  logic [3:0] hammer_rgb;

  hammer_sprite_ctrl_if #(.ADDR_WIDTH(10), .DATA_WIDTH(4)) bus ();

  hammer_sprite_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .x          (x),
    .y          (y),
    .org_x      (org_x),
    .org_y      (org_y),
    .frame_tick (frame_tick),
    .swing      (swing),
    .busy       (busy),
    .hit        (hit),
    .hammer_on  (hammer_on),
    .hammer_rgb (hammer_rgb),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  // Bitmap RAM: one write port, registered read.
  logic [3:0] ram [1024];
  always @(posedge clk) begin
    if (bus.we) ram[bus.addr_w] <= bus.din;
    bus.ram_dout <= ram[bus.addr_r];
  end

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [3:0] ref_mem [1024];
  logic [9:0] last_addr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Host write through the arbiter; bounded wait for the ack.
  task automatic host_write(input logic [9:0] a, input logic [3:0] d);
    bit got;
    got = 1'b0;
    bus.wr_req  = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      if (bus.wr_ack) got = 1'b1;
    end
    bus.wr_req = 1'b0;
    ref_mem[a] = d;
    check("wr_ack_seen", 32'(got), 32'd1);
  endtask

  // Present a pixel, check the RAM address after one cycle and the pixel after three.
  task automatic pixel_test(input logic [9:0] px, input logic [9:0] py,
                            input logic [9:0] ox, input logic [9:0] oy, input int fr);
    logic [9:0] dx, dy, ea;
    logic [3:0] word;
    bit         inb;
    x = px; y = py; org_x = ox; org_y = oy;
    dx  = px - ox;
    dy  = py - oy;
    inb = (int'(dx) < 16) && (int'(dy) < 16);
    ea  = inb ? 10'(fr * 256 + int'(dy) * 16 + int'(dx)) : last_addr;
    step();
    check("addr_r", 32'(bus.addr_r), 32'(ea));
    last_addr = ea;
    step();
    step();
    word = inb ? ref_mem[ea] : 4'd0;
    check("hammer_on", 32'(hammer_on), 32'(inb && word != 4'd0));
    check("hammer_rgb", 32'(hammer_rgb), 32'(word));
  endtask

  initial begin
    logic [3:0] wdat;
    logic [3:0] d;
    logic [9:0] ox, oy;
    int         fr;

    reset_n = 1'b0;
    x = 10'd0; y = 10'd0; org_x = 10'd500; org_y = 10'd500;
    frame_tick = 1'b0; swing = 1'b0;
    bus.wr_req = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    last_addr = '0;
    repeat (3) step();

    check("rst_busy", 32'(busy), 0);
    check("rst_hit", 32'(hit), 0);
    check("rst_addr_r", 32'(bus.addr_r), 0);
    check("rst_hammer_on", 32'(hammer_on), 0);
    check("rst_we", 32'(bus.we), 0);
    check("rst_wr_ack", 32'(bus.wr_ack), 0);
    reset_n = 1'b1;
    step();

    // Fill the whole bitmap with random colours plus a few fixed words.
    for (int a = 0; a < 1024; a++) begin
      d = 4'($urandom_range(0, 15));
      if (a == 'h023) d = 4'd5;
      if (a == 'h024) d = 4'd0;
      host_write(10'(a), d);
    end
    step();

    // Directed addressing, wrap exclusion and transparency.
    pixel_test(10'd103, 10'd52, 10'd100, 10'd50, 0);
    pixel_test(10'd99,  10'd52, 10'd100, 10'd50, 0);
    pixel_test(10'd104, 10'd52, 10'd100, 10'd50, 0);
    pixel_test(10'd115, 10'd65, 10'd100, 10'd50, 0);
    pixel_test(10'd116, 10'd52, 10'd100, 10'd50, 0);

    // Randomized pixels around random origins (including wrap near 1023).
    for (int i = 0; i < 30; i++) begin
      ox = 10'($urandom_range(0, 1023));
      oy = 10'($urandom_range(0, 1023));
      pixel_test(10'(int'(ox) + int'($urandom_range(0, 24)) - 4),
                 10'(int'(oy) + int'($urandom_range(0, 24)) - 4), ox, oy, 0);
    end

    // Single write in IDLE.
    bus.wr_req = 1'b1; bus.wr_addr = 10'h1FF; bus.wr_data = 4'hA;
    step();
    check("wr_we", 32'(bus.we), 1);
    check("wr_ack", 32'(bus.wr_ack), 1);
    check("wr_addr_w", 32'(bus.addr_w), 32'h1FF);
    check("wr_din", 32'(bus.din), 32'hA);
    step();
    check("wr_ack_alt0", 32'(bus.wr_ack), 0);
    check("wr_we_alt0", 32'(bus.we), 0);
    step();
    check("wr_ack_alt1", 32'(bus.wr_ack), 1);
    bus.wr_req = 1'b0;
    ref_mem['h1FF] = 4'hA;
    step();
    check("wr_ack_drop", 32'(bus.wr_ack), 0);

    // Swing with a simultaneous write request held through the animation.
    x = 10'd103; y = 10'd52; org_x = 10'd100; org_y = 10'd50;
    repeat (3) step();
    last_addr = 10'h023;
    wdat = 4'($urandom_range(1, 15));
    bus.wr_req = 1'b1; bus.wr_addr = 10'h155; bus.wr_data = wdat;
    swing = 1'b1;
    step();
    swing = 1'b0;
    check("busy_wind", 32'(busy), 1);
    check("ack_vs_swing", 32'(bus.wr_ack), 0);
    check("we_vs_swing", 32'(bus.we), 0);
    for (int k = 1; k <= 8; k++) begin
      fr = (k <= 6) ? 2 : ((k == 7) ? 3 : 0);
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      check("hit", 32'(hit), 32'(k == 1));
      check("busy", 32'(busy), 32'(k < 8));
      check("ack_busy", 32'(bus.wr_ack), 0);
      check("we_busy", 32'(bus.we), 0);
      if (k == 3) swing = 1'b1;
      step();
      swing = 1'b0;
      check("hit_once", 32'(hit), 0);
      check("ack_after", 32'(bus.wr_ack), 32'(k == 8));
      check("we_after", 32'(bus.we), 32'(k == 8));
      if (k == 8) begin
        check("swing_addr_w", 32'(bus.addr_w), 32'h155);
        check("swing_din", 32'(bus.din), 32'(wdat));
        bus.wr_req = 1'b0;
        ref_mem['h155] = wdat;
      end
      step();
      check("frame_addr", 32'(bus.addr_r), 32'(fr * 256 + 'h23));
      step();
      check("frame_rgb", 32'(hammer_rgb), 32'(ref_mem[fr * 256 + 'h23]));
      check("frame_on", 32'(hammer_on), 32'(ref_mem[fr * 256 + 'h23] != 4'd0));
    end
    repeat (3) step();
    check("busy_end", 32'(busy), 0);
    check("ack_end", 32'(bus.wr_ack), 0);

    // Reset in the strike-entry cycle aborts cleanly.
    swing = 1'b1;
    step();
    swing = 1'b0;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    check("pre_rst_hit", 32'(hit), 1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_hit", 32'(hit), 0);
    check("mid_rst_we", 32'(bus.we), 0);
    check("mid_rst_addr_r", 32'(bus.addr_r), 0);
    check("mid_rst_on", 32'(hammer_on), 0);
    check("mid_rst_rgb", 32'(hammer_rgb), 0);
    @(negedge clk);
    reset_n = 1'b1;
    last_addr = '0;
    step();
    check("post_rst_busy", 32'(busy), 0);
    check("post_rst_hit", 32'(hit), 0);
    pixel_test(10'd103, 10'd52, 10'd100, 10'd50, 0);
    check("post_rst_busy2", 32'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
